tcam_rule_loader: RTL

Rule-programming initiator for the `tcam` setting port. It accepts rule records (priority, byte mask, key, rule ID) from the control plane over a valid/ready interface and buffers them in a 4-entry FIFO. It then drives each record into the TCAM as one set transaction, holding `o_Set_Enable` until the TCAM answers with `i_Set_Done` or a timeout expires. It sits between the host/config logic and `tcam`, and replaces hand-sequenced set pulses.

---
 rtl/tcam_rule_loader.sv | 119 +++++++++++
 1 files changed

// File: rtl/tcam_rule_loader.sv
// Queues host rule records in a 4-deep FIFO and drives each into the TCAM set port,
// holding enable until done (after a minimum hold) or timeout, then one idle gap cycle.
module tcam_rule_loader #(
  parameter int KWID     = 104,
  parameter int MASKWID  = KWID/8,
  parameter int PRIOR    = 8,
  parameter int IDWID    = 8,
  parameter int TOTALWID = KWID+MASKWID+PRIOR,
  parameter int MIN_EN   = 2,
  parameter int TIMEOUT  = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_Rule_Valid,
  input  logic [TOTALWID-1:0] i_Rule_String,
  input  logic [IDWID-1:0]    i_Rule_ID,
  output logic                o_Rule_Ready,
  output logic                o_Set_Enable,
  output logic [TOTALWID-1:0] o_Set_String,
  output logic [IDWID-1:0]    o_Set_ID,
  input  logic                i_Set_Done,
  output logic                o_Busy,
  output logic [IDWID:0]      o_Loaded_Cnt,
  output logic                o_Err,
  input  logic                i_Err_Clr
);

  localparam int EW = TOTALWID + IDWID;
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] MIN_M1 = CW'(MIN_EN - 1);
  localparam logic [CW-1:0] TO_M1  = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, DRIVE, GAP} state_t;

  state_t          state, state_nx;
  logic [EW-1:0]   mem [4];
  logic [1:0]      wr_ptr, rd_ptr;
  logic [2:0]      occ;
  logic [CW-1:0]   hcnt;
  logic            push, pop, done_ok, expire;

  assign o_Rule_Ready = (occ != 3'd4);
  assign push         = i_Rule_Valid && o_Rule_Ready;
  assign o_Set_Enable = (state == DRIVE);
  assign o_Busy       = (occ != 3'd0) || (state != IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  // Done before the minimum hold is ignored; done beats a coincident timeout.
  always_comb begin
    state_nx = state;
    pop      = 1'b0;
    done_ok  = 1'b0;
    expire   = 1'b0;
    case (state)
      IDLE: begin
        if (occ != 3'd0) begin
          pop      = 1'b1;
          state_nx = DRIVE;
        end
      end
      DRIVE: begin
        if (i_Set_Done && (hcnt >= MIN_M1)) begin
          done_ok  = 1'b1;
          state_nx = GAP;
        end else if (hcnt == TO_M1) begin
          expire   = 1'b1;
          state_nx = GAP;
        end
      end
      GAP:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {i_Rule_String, i_Rule_ID};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 2'd1;
      if (pop)  rd_ptr <= rd_ptr + 2'd1;
      case ({push, pop})
        2'b10:   occ <= occ + 3'd1;
        2'b01:   occ <= occ - 3'd1;
        default: occ <= occ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      o_Set_String <= '0;
      o_Set_ID     <= '0;
      hcnt         <= '0;
      o_Loaded_Cnt <= '0;
      o_Err        <= 1'b0;
    end else begin
      if (pop) begin
        {o_Set_String, o_Set_ID} <= mem[rd_ptr];
        hcnt <= '0;
      end else if (state == DRIVE) begin
        hcnt <= hcnt + 1'b1;
      end
      if (done_ok && (o_Loaded_Cnt != '1)) o_Loaded_Cnt <= o_Loaded_Cnt + 1'b1;
      if (expire)         o_Err <= 1'b1;
      else if (i_Err_Clr) o_Err <= 1'b0;
    end
  end

endmodule
